register_tx: RTL and testbench

Serial transmitter that reads an 8-bit register value and shifts it out on a single line as an asynchronous frame: start bit, 8 data bits LSB first, stop bit. It is the read-out counterpart of the loadable `register` block. Its parallel input is driven by a register's `out_o`, and its `tx_o` drives the chip's serial debug/output pin. A bus-side `start_i`/`busy_o`/`done_o` handshake lets the sequencer dump register contents one byte at a time.

---
 rtl/register_tx_pkg.sv | 18 +
 rtl/bit_timer.sv | 40 ++++
 rtl/register_tx.sv | 109 ++++++++++
 tb/tb_register_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_tx_pkg.sv
// register_tx_pkg
// Shared types and line levels for the register read-out serial transmitter.
//   tx_state_t      : frame sequencing states (IDLE, START, DATA, STOP)
//   TX_*_LEVEL      : serial line level driven in each framing phase
package register_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;
  localparam logic TX_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
// Baud counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 and wraps,
// flagging the last cycle of every bit period.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clear_i : holds the counter at zero (used while the transmitter is idle)
//   tick_o  : high during the final cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Free-running within a bit period; clearing lines the first period up with
  // the edge that accepts a new frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Masked by clear so a stale count can never advance the FSM out of idle.
  assign tick_o = !clear_i && (count == LAST_COUNT);

endmodule

// File: rtl/register_tx.sv
// register_tx
// Serial read-out transmitter: captures a register value and sends it as an
// asynchronous frame (start bit, DATA_W data bits LSB first, stop bit).
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset; aborts any frame in flight
//   start_i : transmit request, only honoured while idle
//   data_i  : payload, captured on the accepting edge
//   tx_o    : serial line, idles high
//   busy_o  : high while a frame is being sent
//   done_o  : one-cycle pulse after the stop bit completes
module register_tx
  import register_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_cnt;
  logic              bit_tick;
  logic              timer_clear;

  // Baud counter is held in reset while idle so every frame starts with a
  // full-length start bit regardless of when start_i arrives.
  assign timer_clear = (state == IDLE);
  assign shift_next  = shift_reg >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(timer_clear),
    .tick_o (bit_tick)
  );

  // Frame sequencer. tx_o is registered and is loaded with the level of the
  // phase being entered, so the line changes exactly on bit boundaries.
  // done_o defaults low and is set only on the STOP->IDLE transition, which
  // makes it a single-cycle pulse; a start in that idle cycle is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx_o      <= TX_IDLE_LEVEL;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_o <= TX_IDLE_LEVEL;
          if (start_i) begin
            shift_reg <= data_i;
            bit_cnt   <= '0;
            state     <= START;
            tx_o      <= TX_START_LEVEL;
            busy_o    <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx_o  <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx_o  <= TX_STOP_LEVEL;
            end else begin
              tx_o <= shift_next[0];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            state  <= IDLE;
            tx_o   <= TX_IDLE_LEVEL;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_tx.sv
// tb_register_tx
// Bench for register_tx. Three instances (CLKS_PER_BIT = 4, 2, 7) share clock
// and reset. A frame-level model predicts tx/busy/done for each instance and
// is compared every cycle; directed sequences add hand-computed expectations.
module tb_register_tx;

  localparam int NINST = 3;

  logic       clk;
  logic       rst;
  logic       start_in [NINST];
  logic [7:0] data_in  [NINST];
  logic       tx_out   [NINST];
  logic       busy_out [NINST];
  logic       done_out [NINST];

  int checks;
  int errors;
  bit check_en;

  register_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut_cpb4 (
    .clk_i(clk), .rst_i(rst), .start_i(start_in[0]), .data_i(data_in[0]),
    .tx_o(tx_out[0]), .busy_o(busy_out[0]), .done_o(done_out[0])
  );

  register_tx #(.CLKS_PER_BIT(2), .DATA_W(8)) dut_cpb2 (
    .clk_i(clk), .rst_i(rst), .start_i(start_in[1]), .data_i(data_in[1]),
    .tx_o(tx_out[1]), .busy_o(busy_out[1]), .done_o(done_out[1])
  );

  register_tx #(.CLKS_PER_BIT(7), .DATA_W(8)) dut_cpb7 (
    .clk_i(clk), .rst_i(rst), .start_i(start_in[2]), .data_i(data_in[2]),
    .tx_o(tx_out[2]), .busy_o(busy_out[2]), .done_o(done_out[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb_of(input int inst);
    if (inst == 1) return 2;
    if (inst == 2) return 7;
    return 4;
  endfunction

  // Single comparison point: every check is counted here.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level model: once a start is accepted, the line follows the
  // 10-bit frame {stop, data, start} with each bit lasting cpb cycles; the
  // frame ends after 10*cpb cycles with one idle cycle carrying done.
  bit         m_active [NINST];
  int         m_t      [NINST];
  logic [9:0] m_frame  [NINST];
  logic       exp_tx   [NINST];
  logic       exp_busy [NINST];
  logic       exp_done [NINST];

  always @(posedge clk or posedge rst) begin
    bit         act;
    int         t;
    logic [9:0] fr;
    logic       d;
    for (int i = 0; i < NINST; i++) begin
      if (rst) begin
        m_active[i] <= 1'b0;
        m_t[i]      <= 0;
        m_frame[i]  <= '1;
        exp_tx[i]   <= 1'b1;
        exp_busy[i] <= 1'b0;
        exp_done[i] <= 1'b0;
      end else begin
        act = m_active[i];
        t   = m_t[i];
        fr  = m_frame[i];
        d   = 1'b0;
        if (act) begin
          t = t + 1;
          if (t == 10 * cpb_of(i)) begin
            act = 1'b0;
            d   = 1'b1;
          end
        end else if (start_in[i]) begin
          act = 1'b1;
          t   = 0;
          fr  = {1'b1, data_in[i], 1'b0};
        end
        m_active[i] <= act;
        m_t[i]      <= t;
        m_frame[i]  <= fr;
        exp_done[i] <= d;
        exp_busy[i] <= act;
        exp_tx[i]   <= act ? fr[t / cpb_of(i)] : 1'b1;
      end
    end
  end

  // Continuous comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NINST; i++) begin
        check_output($sformatf("model_tx[%0d]", i),   {31'd0, tx_out[i]},   {31'd0, exp_tx[i]});
        check_output($sformatf("model_busy[%0d]", i), {31'd0, busy_out[i]}, {31'd0, exp_busy[i]});
        check_output($sformatf("model_done[%0d]", i), {31'd0, done_out[i]}, {31'd0, exp_done[i]});
      end
    end
  end

  // Launches one frame on an instance and watches it from the cycle after
  // the accepting edge (t=0). Optionally re-pulses start with 8'hFF at
  // restart_at. Returns mid-bit samples of the line and done statistics.
  task automatic apply_stimulus(input int inst, input logic [7:0] d,
                                input int restart_at, output logic [9:0] bits,
                                output int done_at, output int done_cnt);
    int cpb;
    cpb      = cpb_of(inst);
    bits     = '0;
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk);
    data_in[inst]  = d;
    start_in[inst] = 1'b1;
    @(negedge clk);
    start_in[inst] = 1'b0;
    for (int t = 0; t < 10 * cpb + 20; t++) begin
      if ((t % cpb) == (cpb / 2) && (t / cpb) < 10) bits[t / cpb] = tx_out[inst];
      if (done_out[inst]) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (t == restart_at) begin
        data_in[inst]  = 8'hFF;
        start_in[inst] = 1'b1;
      end else if (t == restart_at + 1) begin
        start_in[inst] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    int         done_at;
    int         done_cnt;
    int         low_cnt;
    logic       a5_bits [10];

    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < NINST; i++) begin
      start_in[i] = 1'b0;
      data_in[i]  = 8'h00;
    end
    #1 check_en = 1'b1;

    // Reset state held quiet for 20 cycles.
    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0 || c == 19) begin
        check_output("reset_tx",   {31'd0, tx_out[0]},   32'd1);
        check_output("reset_busy", {31'd0, busy_out[0]}, 32'd0);
        check_output("reset_done", {31'd0, done_out[0]}, 32'd0);
      end
    end

    // Single frame of 8'hA5: line reads 0,1,0,1,0,0,1,0,1,1 mid-bit.
    $display("[TB] single frame A5");
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_stimulus(0, 8'hA5, -1, bits, done_at, done_cnt);
    for (int j = 0; j < 10; j++)
      check_output($sformatf("a5_bit%0d", j), {31'd0, bits[j]}, {31'd0, a5_bits[j]});
    check_output("a5_done_at",  done_at,  32'd40);
    check_output("a5_done_cnt", done_cnt, 32'd1);

    // Start re-pulsed mid-frame with different data is ignored.
    $display("[TB] ignored start");
    apply_stimulus(0, 8'h3C, 10, bits, done_at, done_cnt);
    check_output("ign_frame",    {22'd0, bits}, {22'd0, 10'b1_0011_1100_0});
    check_output("ign_done_at",  done_at,       32'd40);
    check_output("ign_done_cnt", done_cnt,      32'd1);
    check_output("ign_idle",     {31'd0, busy_out[0]}, 32'd0);

    // Back-to-back frames with start held high.
    $display("[TB] back to back");
    @(negedge clk);
    data_in[0]  = 8'h01;
    start_in[0] = 1'b1;
    @(negedge clk);
    data_in[0] = 8'h80;
    low_cnt  = 0;
    done_cnt = 0;
    bits     = '0;
    for (int t = 0; t < 100; t++) begin
      if (t <= 80 && !busy_out[0]) low_cnt++;
      if (done_out[0]) done_cnt++;
      if (t == 40) check_output("b2b_gap_tx",  {31'd0, tx_out[0]}, 32'd1);
      if (t == 41) check_output("b2b_start2",  {31'd0, tx_out[0]}, 32'd0);
      if (t >= 41 && t < 81 && ((t - 41) % 4) == 2) bits[(t - 41) / 4] = tx_out[0];
      if (t == 41) start_in[0] = 1'b0;
      @(negedge clk);
    end
    check_output("b2b_busy_low", low_cnt,       32'd1);
    check_output("b2b_done_cnt", done_cnt,      32'd2);
    check_output("b2b_frame2",   {22'd0, bits}, {22'd0, 10'b1_1000_0000_0});

    // Reset asserted during data bit 3 of an all-zero frame.
    $display("[TB] reset mid-frame");
    @(negedge clk);
    data_in[0]  = 8'h00;
    start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0;
    repeat (18) @(negedge clk);
    check_output("mid_bit3_tx", {31'd0, tx_out[0]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_output("async_tx",   {31'd0, tx_out[0]},   32'd1);
    check_output("async_busy", {31'd0, busy_out[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_out[0]) done_cnt++;
    end
    check_output("abort_no_done", done_cnt, 32'd0);
    apply_stimulus(0, 8'h00, -1, bits, done_at, done_cnt);
    check_output("post_rst_frame",   {22'd0, bits}, {22'd0, 10'b1_0000_0000_0});
    check_output("post_rst_done_at", done_at,       32'd40);

    // Bit-period sweep on the other instances.
    $display("[TB] parameter sweep");
    apply_stimulus(1, 8'hC3, -1, bits, done_at, done_cnt);
    check_output("cpb2_frame",   {22'd0, bits}, {22'd0, 10'b1_1100_0011_0});
    check_output("cpb2_done_at", done_at,       32'd20);
    check_output("cpb2_done_cnt", done_cnt,     32'd1);
    apply_stimulus(2, 8'hC3, -1, bits, done_at, done_cnt);
    check_output("cpb7_frame",   {22'd0, bits}, {22'd0, 10'b1_1100_0011_0});
    check_output("cpb7_done_at", done_at,       32'd70);
    check_output("cpb7_done_cnt", done_cnt,     32'd1);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
